msg_frame_deserializer: RTL and testbench
=========================================

# msg_frame_deserializer

Serial-to-parallel frame assembler on the receive side of the half-duplex message link. It consumes the MSB-first bit stream produced by the per-message parallel-to-serial shift registers and packs `MSG_NUM` consecutive `MSG_WIDTH`-bit messages into one parallel frame for the node-processing units. A valid/ready output handshake and a single holding register let one frame be offered downstream while the next frame is being shifted in.

## Interface
- `MSG_WIDTH`, 4: bits per message.
- `MSG_NUM`, 6: messages per frame. Must be ≥ 1.
- `sys_clk`  input  1  system clock; all logic is rising-edge.
- `sys_rst`  input  1  synchronous, active-high reset.
- `serial_in`  input  1  serial data bit.
- `serial_valid`  input  1  `serial_in` carries a bit in this cycle. When low, the block stalls.
- `frame_start`  input  1  qualified by `serial_valid`; marks the current bit as the MSB of message 0.
- `frame_out`  output  `MSG_NUM*MSG_WIDTH`  assembled frame. Message k occupies bits `[k*MSG_WIDTH +: MSG_WIDTH]`.
- `frame_valid`  output  1  `frame_out` holds an unconsumed frame.
- `frame_ready`  input  1  downstream accepts the frame on a cycle where `frame_valid && frame_ready`.
- `busy`  output  1  a frame is partially received.
- `overflow`  output  1  sticky flag: a completed frame was dropped.

## Operation
- Internal state:
  - Shift register `sh` of width `MSG_WIDTH`.
  - Bit counter `bc` over 0..`MSG_WIDTH`-1.
  - Message counter `mc` over 0..`MSG_NUM`-1.
  - Assembly buffer `asm` of width `MSG_NUM*MSG_WIDTH`.
  - Output register `out_q`, which drives `frame_out`.
- FSM states:
  - IDLE: no frame in progress. `busy` = 0.
  - RECV: frame in progress. `busy` = 1.
- IDLE → RECV when `serial_valid && frame_start`. That bit is captured as bit 0, with `bc` = 1 and `mc` = 0.
- While in IDLE, any `serial_valid` bit without `frame_start` is ignored.
- In RECV, each `serial_valid` bit shifts in MSB-first: `sh <= {sh[MSG_WIDTH-2:0], serial_in}`. For `MSG_WIDTH` = 1, `sh <= serial_in`.
- When `bc` reaches `MSG_WIDTH`-1 with a valid bit, the completed message (`sh` including the current bit) is written to `asm` slot `mc`. Then `bc` → 0 and `mc` increments.
- Frame completion: the last bit of message `MSG_NUM`-1 completes the frame. The full frame (with the final message merged) goes to `out_q` if the output slot is free, or is being freed in the same cycle. The FSM then returns to IDLE.
- The output slot is free when `!frame_valid` or (`frame_valid && frame_ready`).
- Completion with the slot occupied and not accepted:
  - The new frame is dropped and `out_q` is kept unchanged.
  - `overflow` is set to 1.
  - The FSM still returns to IDLE.
- `frame_start` asserted in RECV (resync):
  - The partial frame is discarded with no error.
  - The current bit becomes bit 0 of a fresh frame, with `bc` = 1 and `mc` = 0.
  - The FSM stays in RECV.
- `serial_valid` low: `bc`, `mc`, `sh`, `asm` and the FSM state hold. `frame_start` is ignored.
- Output handshake:
  - `frame_valid` is set on load of `out_q`.
  - It clears on `frame_valid && frame_ready` unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
  - `frame_out` is stable while `frame_valid && !frame_ready`.
- `overflow` is cleared only by `sys_rst`.

## Timing
- Reset (`sys_rst` high at an edge):
  - FSM → IDLE.
  - `frame_valid` = 0, `busy` = 0, `overflow` = 0, `frame_out` = 0.
  - All counters and buffers are zeroed.
- Reset mid-frame discards the partial frame and any held output frame.
- Latency: the final bit is sampled at edge N. From edge N, `frame_valid` = 1 and `frame_out` is valid, so the frame is visible in the cycle after the last bit.
- Minimum frame period is `MSG_NUM*MSG_WIDTH` valid cycles. Back-to-back frames with no idle cycle are supported: `frame_start` may coincide with the cycle right after completion.
- `busy` rises at the edge sampling the start bit. It falls at the completion edge.
- `frame_ready` may be high without `frame_valid`; this has no effect.

## Test plan
- **Reset values.** Drive `sys_rst` for 2 cycles with `serial_valid` = 1 → all outputs are 0 and the FSM is IDLE. Then send bits without `frame_start` → no `busy`, no `frame_valid`.
- **Single frame.** `MSG_WIDTH` = 4, `MSG_NUM` = 2. Send start + bits 1010, then 0111, with `frame_ready` = 1 → `frame_out` = 8'h7A and `frame_valid` high for exactly one cycle after the 8th bit.
- **Stalls.** Same frame with `serial_valid` low for 3 random cycles between bits → identical `frame_out`, delayed by the number of stall cycles.
- **Back-to-back with simultaneous accept.** Two back-to-back frames (0x7A, then 0x3C) with `frame_ready` first asserted in the completion cycle of frame 2 → frame 2 loads on the accept edge, `frame_valid` stays 1, and `overflow` = 0.
- **Overflow.** Two frames with `frame_ready` = 0 throughout → `frame_out` stays 0x7A, `overflow` = 1, and stays sticky after a later accept.
- **Resync.** Assert `frame_start` mid-frame after 5 bits, then send a full frame 0xC3 → `frame_out` = 0xC3, no overflow, and exactly one `frame_valid` assertion.

Source files
------------

// File: rtl/msg_frame_deserializer_if.sv
// Serial receive stream plus parallel frame output with valid/ready handshake.
// Latency: none, signal bundle only.
// Backpressure: frame_ready from the consumer, no backpressure on the serial side.
interface msg_frame_deserializer_if #(
    parameter int MSG_WIDTH = 4,
    parameter int MSG_NUM   = 6
);
    logic                         serial_in;
    logic                         serial_valid;
    logic                         frame_start;
    logic [MSG_NUM*MSG_WIDTH-1:0] frame_out;
    logic                         frame_valid;
    logic                         frame_ready;
    logic                         busy;
    logic                         overflow;

    // Producer/consumer side: drives the serial stream and frame_ready.
    modport master (
        output serial_in, serial_valid, frame_start, frame_ready,
        input  frame_out, frame_valid, busy, overflow
    );

    // Deserializer side.
    modport slave (
        input  serial_in, serial_valid, frame_start, frame_ready,
        output frame_out, frame_valid, busy, overflow
    );
endinterface

// File: rtl/msg_frame_deserializer.sv
// Packs MSG_NUM MSB-first serial messages of MSG_WIDTH bits into one parallel frame.
// Latency: frame visible the cycle after its last bit is sampled.
// Backpressure: one holding register; a frame completing into an occupied, unaccepted slot is dropped and flagged.
module msg_frame_deserializer #(
    parameter int MSG_WIDTH = 4,
    parameter int MSG_NUM   = 6
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    msg_frame_deserializer_if.slave bus
);
    localparam int FW  = MSG_NUM * MSG_WIDTH;
    localparam int BCW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
    localparam int MCW = (MSG_NUM > 1) ? $clog2(MSG_NUM) : 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(MSG_WIDTH - 1);
    localparam logic [MCW-1:0] MC_LAST = MCW'(MSG_NUM - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t               state, state_n;
    logic [MSG_WIDTH-1:0] sh, sh_n, sh_shift;
    logic [BCW-1:0]       bc, bc_n, eff_bc;
    logic [MCW-1:0]       mc, mc_n, eff_mc;
    logic [FW-1:0]        asm_q, asm_n, out_q, out_n;
    logic                 fv_q, fv_n, ovf_q, ovf_n;
    logic                 take_bit, restart, msg_done, frame_done, slot_free;

    // Shift path: a single-bit message is just the incoming bit.
    generate
        if (MSG_WIDTH == 1) begin : g_w1
            assign sh_shift = bus.serial_in;
        end else begin : g_wn
            assign sh_shift = {sh[MSG_WIDTH-2:0], bus.serial_in};
        end
    endgenerate

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    // Next-state, counter, assembly and output-slot logic. A start bit is
    // handled as bit 0 of message 0 regardless of the current position, which
    // covers both the IDLE entry and the mid-frame resync.
    always_comb begin
        state_n  = state;
        sh_n     = sh;
        bc_n     = bc;
        mc_n     = mc;
        asm_n    = asm_q;
        out_n    = out_q;
        fv_n     = fv_q;
        ovf_n    = ovf_q;

        restart    = bus.serial_valid && bus.frame_start;
        take_bit   = bus.serial_valid && (state == RECV || bus.frame_start);
        eff_bc     = restart ? '0 : bc;
        eff_mc     = restart ? '0 : mc;
        msg_done   = take_bit && (eff_bc == BC_LAST);
        frame_done = msg_done && (eff_mc == MC_LAST);
        slot_free  = !fv_q || bus.frame_ready;

        if (take_bit) begin
            sh_n    = sh_shift;
            state_n = frame_done ? IDLE : RECV;
            if (msg_done) begin
                for (int k = 0; k < MSG_NUM; k++) begin
                    if (eff_mc == MCW'(k)) asm_n[k*MSG_WIDTH +: MSG_WIDTH] = sh_shift;
                end
                bc_n = '0;
                mc_n = frame_done ? '0 : eff_mc + 1'b1;
            end else begin
                bc_n = eff_bc + 1'b1;
                mc_n = eff_mc;
            end
        end

        // asm_n already holds the final message when the frame completes.
        if (frame_done && slot_free) begin
            out_n = asm_n;
            fv_n  = 1'b1;
        end else if (fv_q && bus.frame_ready) begin
            fv_n  = 1'b0;
        end

        if (frame_done && !slot_free) ovf_n = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh    <= '0;
            bc    <= '0;
            mc    <= '0;
            asm_q <= '0;
            out_q <= '0;
            fv_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sh    <= sh_n;
            bc    <= bc_n;
            mc    <= mc_n;
            asm_q <= asm_n;
            out_q <= out_n;
            fv_q  <= fv_n;
            ovf_q <= ovf_n;
        end
    end

    assign bus.frame_out   = out_q;
    assign bus.frame_valid = fv_q;
    assign bus.busy        = (state == RECV);
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_msg_frame_deserializer.sv
// Bench for msg_frame_deserializer: directed scenarios plus random traffic against a bit-queue model.
// Latency: outputs checked 1 time unit after every rising edge.
// Backpressure: frame_ready driven directly by the bench.
module tb_msg_frame_deserializer;
    localparam int W  = 4;
    localparam int N  = 2;
    localparam int FW = W * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msg_frame_deserializer_if #(.MSG_WIDTH(W), .MSG_NUM(N)) bus ();

    msg_frame_deserializer #(.MSG_WIDTH(W), .MSG_NUM(N)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int vld_pulses = 0;

    // Reference model: bits of the frame in progress, held output frame, sticky flag.
    bit          m_in_frame;
    bit          m_bits[$];
    logic [FW-1:0] m_out;
    bit          m_valid;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step(input bit rst_i, input bit v, input bit b, input bit s, input bit r);
        logic [FW-1:0] f;
        bit done;
        f = '0;
        done = 1'b0;
        if (rst_i) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_out   = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        if (v) begin
            if (s) begin
                m_bits.delete();
                m_bits.push_back(b);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                m_bits.push_back(b);
            end
            if (m_in_frame && m_bits.size() == FW) begin
                // Stream position k*W+i is bit (W-1-i) of message k.
                for (int k = 0; k < N; k++)
                    for (int i = 0; i < W; i++)
                        f[k*W + (W-1-i)] = m_bits[k*W + i];
                done = 1'b1;
                m_in_frame = 1'b0;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_out   = f;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input bit rst_i, input bit v, input bit b, input bit s, input bit r);
        rst              = rst_i;
        bus.serial_valid = v;
        bus.serial_in    = b;
        bus.frame_start  = s;
        bus.frame_ready  = r;
        @(posedge clk);
        model_step(rst_i, v, b, s, r);
        #1;
        chk("busy", 32'(bus.busy), 32'(m_in_frame));
        chk("fvld", 32'(bus.frame_valid), 32'(m_valid));
        chk("fout", 32'(bus.frame_out), 32'(m_out));
        chk("ovf",  32'(bus.overflow), 32'(m_ovf));
        if (bus.frame_valid) vld_pulses++;
    endtask

    task automatic rbit(output bit b);
        b = 1'($urandom_range(0, 1));
    endtask

    // Sends one frame, message 0 first, each message MSB first; stalls are
    // spread randomly between bits, with random frame_start while stalled.
    task automatic send_frame(input logic [FW-1:0] f, input bit r_body, input bit r_last, input int stalls);
        int left;
        int n;
        bit sb;
        bit st;
        left = stalls;
        for (int j = 0; j < FW; j++) begin
            if (j > 0 && left > 0) begin
                n = (j == FW-1) ? left : int'($urandom_range(0, left));
                for (int q = 0; q < n; q++) begin
                    rbit(sb);
                    rbit(st);
                    cycle(1'b0, 1'b0, sb, st, r_body);
                end
                left -= n;
            end
            cycle(1'b0, 1'b1, f[(j/W)*W + (W-1-(j%W))], j == 0, (j == FW-1) ? r_last : r_body);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit b;
        bit v;
        bit s;
        bit r;
        rst = 1'b1;
        bus.serial_valid = 1'b0;
        bus.serial_in    = 1'b0;
        bus.frame_start  = 1'b0;
        bus.frame_ready  = 1'b0;
        m_in_frame = 1'b0;
        m_out = '0;
        m_valid = 1'b0;
        m_ovf = 1'b0;

        // Reset with serial_valid high, then stray bits with no start.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_fvld", 32'(bus.frame_valid), 32'd0);
        chk("rst_fout", 32'(bus.frame_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            rbit(b);
            cycle(1'b0, 1'b1, b, 1'b0, 1'b1);
        end
        chk("nostart_busy", 32'(bus.busy), 32'd0);
        chk("nostart_fvld", 32'(bus.frame_valid), 32'd0);

        // Single frame 0x7A with ready high: exactly one valid cycle.
        vld_pulses = 0;
        send_frame(8'h7A, 1'b1, 1'b1, 0);
        chk("single_vld", 32'(bus.frame_valid), 32'd1);
        chk("single_out", 32'(bus.frame_out), 32'h7A);
        chk("single_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_pulses", 32'(vld_pulses), 32'd1);

        // Same frame with three stall cycles.
        send_frame(8'h7A, 1'b1, 1'b1, 3);
        chk("stall_vld", 32'(bus.frame_valid), 32'd1);
        chk("stall_out", 32'(bus.frame_out), 32'h7A);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back, accept arrives on the completion cycle of frame 2.
        do_reset();
        send_frame(8'h7A, 1'b0, 1'b0, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("b2b_vld", 32'(bus.frame_valid), 32'd1);
        chk("b2b_out", 32'(bus.frame_out), 32'h3C);
        chk("b2b_ovf", 32'(bus.overflow), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_drain", 32'(bus.frame_valid), 32'd0);

        // Overflow: nobody accepts, second frame dropped.
        do_reset();
        send_frame(8'h7A, 1'b0, 1'b0, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("ovf_out", 32'(bus.frame_out), 32'h7A);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("ovf_drained", 32'(bus.frame_valid), 32'd0);

        // Resync after five bits, then a full 0xC3 frame.
        do_reset();
        vld_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            rbit(b);
            cycle(1'b0, 1'b1, b, i == 0, 1'b1);
        end
        send_frame(8'hC3, 1'b1, 1'b1, 0);
        chk("resync_out", 32'(bus.frame_out), 32'hC3);
        chk("resync_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("resync_pulses", 32'(vld_pulses), 32'd1);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rbit(b);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 299) == 0, v, b, s, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
